// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM state encoding, funct3 access
// encodings and the alignment/legality check applied when a request is accepted.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; any other encoding is an error.
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges store data into a previously read word for byte/halfword stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int RegBits = 32
) (
    input  logic [2:0]         funct3,
    input  logic [1:0]         byte_off,
    input  logic [RegBits-1:0] rd_word,
    input  logic [RegBits-1:0] wdata,
    output logic [RegBits-1:0] load_data,
    output logic [RegBits-1:0] store_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = rd_word[{byte_off, 3'b000} +: 8];
        ld_half   = rd_word[{byte_off[1], 4'b0000} +: 16];
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{(RegBits-8){ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {{(RegBits-8){1'b0}}, ld_byte};
            F3_H:    load_data = {{(RegBits-16){ld_half[15]}}, ld_half};
            F3_HU:   load_data = {{(RegBits-16){1'b0}}, ld_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        store_word = rd_word;
        case (funct3[1:0])
            2'b00:   store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01:   store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the core and a word-wide data
// memory; byte/halfword stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int RegBits = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [2:0]         funct3_i,
    input  logic [RegBits-1:0] addr_i,
    input  logic [RegBits-1:0] wdata_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [RegBits-1:0] rdata_o,
    output logic               misaligned_o,
    output logic [RegBits-1:0] mem_a_o,
    output logic [RegBits-1:0] mem_wd_o,
    output logic               mem_we_o,
    input  logic [RegBits-1:0] mem_rd_i
);

    lsu_state_e         state_q, state_d;
    logic [RegBits-1:0] addr_q, wdata_q, rmw_q, rdata_q;
    logic [2:0]         funct3_q;
    logic               we_q, mis_q;
    logic               accept, req_mis;
    logic [RegBits-1:0] load_data, store_word;

    assign accept  = (state_q == ST_IDLE) && req_i;
    assign req_mis = is_misaligned(we_i, funct3_i, addr_i[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_mis)              state_d = ST_RESP;
                    else if (!we_i)           state_d = ST_LOAD;
                    else if (funct3_i == F3_W) state_d = ST_WRITE;
                    else                      state_d = ST_READ;
                end
            end
            ST_LOAD:  state_d = ST_RESP;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            mis_q    <= 1'b0;
            rmw_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= addr_i;
                wdata_q  <= wdata_i;
                funct3_q <= funct3_i;
                we_q     <= we_i;
                mis_q    <= req_mis;
            end
            if (state_q == ST_LOAD) rdata_q <= load_data;
            if (state_q == ST_READ) rmw_q   <= mem_rd_i;
        end
    end

    lsu_align #(
        .RegBits(RegBits)
    ) u_align (
        .funct3    (funct3_q),
        .byte_off  (addr_q[1:0]),
        .rd_word   ((state_q == ST_LOAD) ? mem_rd_i : rmw_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    assign ready_o      = (state_q == ST_IDLE);
    assign valid_o      = (state_q == ST_RESP);
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign mem_a_o      = {addr_q[RegBits-1:2], 2'b00};
    assign mem_wd_o     = we_q ? store_word : '0;
    // Gated by reset so a write cycle interrupted by reset never reaches memory.
    assign mem_we_o     = (state_q == ST_WRITE) && rst_ni;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model and a
// scoreboard of expected completions.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ready_o, valid_o, misaligned_o, mem_we_o;
    logic [31:0] rdata_o, mem_a_o, mem_wd_o, mem_rd_i;

    logic [31:0] mem [256];
    logic        preloaded = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.RegBits(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .rdata_o     (rdata_o),
        .misaligned_o(misaligned_o),
        .mem_a_o     (mem_a_o),
        .mem_wd_o    (mem_wd_o),
        .mem_we_o    (mem_we_o),
        .mem_rd_i    (mem_rd_i)
    );

    assign mem_rd_i = mem[mem_a_o[9:2]];

    always @(posedge clk_i) begin
        if (!preloaded) begin
            mem[64]   <= 32'h8844_22F0;
            mem[65]   <= 32'h0000_0000;
            preloaded <= 1'b1;
        end else if (mem_we_o) begin
            mem[mem_a_o[9:2]] <= mem_wd_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: drive, then watch up to 6 cycles for write and completion.
    task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int exp_lat, input logic [31:0] exp_rdata,
                             input logic exp_mis, input int exp_we_cyc,
                             input logic [31:0] exp_wd);
        int   got_lat, we_cyc, we_cnt;
        exp_t e;
        got_lat = -1;
        we_cyc  = -1;
        we_cnt  = 0;
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        sb_q.push_back('{rdata: exp_rdata, mis: exp_mis});
        @(negedge clk_i);
        check({tag, " ready"}, {31'b0, ready_o}, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk_i);
            if (k == 1) begin #1; req_i = 1'b0; end
            @(negedge clk_i);
            if (k == 1) check({tag, " mem_a"}, mem_a_o, {addr[31:2], 2'b00});
            if (mem_we_o) begin
                we_cnt++;
                we_cyc = k;
                check({tag, " wd"}, mem_wd_o, exp_wd);
            end
            if (valid_o) begin
                got_lat = k;
                break;
            end
        end
        check({tag, " latency"}, got_lat, exp_lat);
        check({tag, " we_cycle"}, we_cyc, exp_we_cyc);
        check({tag, " we_count"}, we_cnt, (exp_we_cyc > 0) ? 1 : 0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " rdata"}, rdata_o, e.rdata);
            check({tag, " mis"}, {31'b0, misaligned_o}, {31'b0, e.mis});
        end
        last_rdata = exp_rdata;
    endtask

    initial begin
        exp_t e;
        int   vcnt;

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst ready", {31'b0, ready_o}, 32'd1);
        check("rst valid", {31'b0, valid_o}, 32'd0);
        check("rst rdata", rdata_o, 32'd0);
        check("rst mis", {31'b0, misaligned_o}, 32'd0);
        check("rst mem_a", mem_a_o, 32'd0);
        check("rst mem_wd", mem_wd_o, 32'd0);
        check("rst mem_we", {31'b0, mem_we_o}, 32'd0);

        do_access("LB100", 1'b0, F3_B, 32'h100, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, -1, 32'h0);

        // SH whose write cycle is hit by reset
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = F3_H; addr_i = 32'h100; wdata_i = 32'h0000_5555;
        @(negedge clk_i);
        check("abort ready", {31'b0, ready_o}, 32'd1);
        @(posedge clk_i); #1 req_i = 1'b0;
        @(negedge clk_i);
        check("abort read we", {31'b0, mem_we_o}, 32'd0);
        @(posedge clk_i); #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort write we", {31'b0, mem_we_o}, 32'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("abort ready after", {31'b0, ready_o}, 32'd1);
        check("abort rdata", rdata_o, 32'd0);
        check("abort mem_a", mem_a_o, 32'd0);
        check("abort mem_wd", mem_wd_o, 32'd0);
        check("abort word", mem[64], 32'h8844_22F0);
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (valid_o || mem_we_o) vcnt++;
            @(negedge clk_i);
        end
        check("abort no valid", vcnt, 0);
        last_rdata = '0;

        do_access("LHU102", 1'b0, F3_HU, 32'h102, 32'h0, 2, 32'h0000_8844, 1'b0, -1, 32'h0);
        do_access("LH102",  1'b0, F3_H,  32'h102, 32'h0, 2, 32'hFFFF_8844, 1'b0, -1, 32'h0);
        do_access("LBU103", 1'b0, F3_BU, 32'h103, 32'h0, 2, 32'h0000_0088, 1'b0, -1, 32'h0);
        do_access("LB101",  1'b0, F3_B,  32'h101, 32'h0, 2, 32'h0000_0022, 1'b0, -1, 32'h0);
        do_access("LW100",  1'b0, F3_W,  32'h100, 32'h0, 2, 32'h8844_22F0, 1'b0, -1, 32'h0);
        do_access("LH100",  1'b0, F3_H,  32'h100, 32'h0, 2, 32'h0000_22F0, 1'b0, -1, 32'h0);

        do_access("SB101", 1'b1, F3_B, 32'h101, 32'h0000_00AB, 3, last_rdata, 1'b0, 2, 32'h8844_ABF0);
        check("SB101 word", mem[64], 32'h8844_ABF0);
        do_access("LW100b", 1'b0, F3_W, 32'h100, 32'h0, 2, 32'h8844_ABF0, 1'b0, -1, 32'h0);

        do_access("LW102mis", 1'b0, F3_W, 32'h102, 32'h0, 1, last_rdata, 1'b1, -1, 32'h0);
        do_access("LH101mis", 1'b0, F3_H, 32'h101, 32'h0, 1, last_rdata, 1'b1, -1, 32'h0);
        do_access("SH103mis", 1'b1, F3_H, 32'h103, 32'h1111, 1, last_rdata, 1'b1, -1, 32'h0);
        do_access("L011mis", 1'b0, 3'b011, 32'h100, 32'h0, 1, last_rdata, 1'b1, -1, 32'h0);
        do_access("S100mis", 1'b1, 3'b100, 32'h100, 32'h77, 1, last_rdata, 1'b1, -1, 32'h0);
        check("mis word", mem[64], 32'h8844_ABF0);

        do_access("SH102", 1'b1, F3_H, 32'h102, 32'hCAFE_1234, 3, last_rdata, 1'b0, 2, 32'h1234_ABF0);
        do_access("LHU102b", 1'b0, F3_HU, 32'h102, 32'h0, 2, 32'h0000_1234, 1'b0, -1, 32'h0);

        // SW then LW with req_i held high throughout
        @(posedge clk_i); #1;
        req_i = 1'b1; we_i = 1'b1; funct3_i = F3_W; addr_i = 32'h104; wdata_i = 32'hDEAD_BEEF;
        sb_q.push_back('{rdata: last_rdata, mis: 1'b0});
        @(negedge clk_i);
        check("b2b sw ready", {31'b0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        we_i = 1'b0; funct3_i = F3_W; wdata_i = 32'h0;
        @(negedge clk_i);
        check("b2b busy ready", {31'b0, ready_o}, 32'd0);
        check("b2b sw we", {31'b0, mem_we_o}, 32'd1);
        check("b2b sw a", mem_a_o, 32'h104);
        check("b2b sw wd", mem_wd_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check("b2b sw valid", {31'b0, valid_o}, 32'd1);
        e = sb_q.pop_front();
        check("b2b sw rdata", rdata_o, e.rdata);
        check("b2b sw mis", {31'b0, misaligned_o}, {31'b0, e.mis});
        sb_q.push_back('{rdata: 32'hDEAD_BEEF, mis: 1'b0});
        @(negedge clk_i);
        check("b2b lw ready", {31'b0, ready_o}, 32'd1);
        check("b2b idle valid", {31'b0, valid_o}, 32'd0);
        @(posedge clk_i); #1 req_i = 1'b0;
        @(negedge clk_i);
        check("b2b lw load", {31'b0, valid_o}, 32'd0);
        @(negedge clk_i);
        check("b2b lw valid", {31'b0, valid_o}, 32'd1);
        e = sb_q.pop_front();
        check("b2b lw rdata", rdata_o, e.rdata);
        check("b2b lw mis", {31'b0, misaligned_o}, {31'b0, e.mis});
        @(negedge clk_i);
        check("b2b end ready", {31'b0, ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RegBits, default 32, data/address width; only 32 is supported.
REQ-002 SHALL have clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_ni  in  1  reset, synchronous, active-low.
REQ-004 SHALL have req_i  in  1  core request; sampled only when ready_o=1.
REQ-005 SHALL have we_i  in  1  1=store, 0=load.
REQ-006 SHALL have funct3_i  in  3  access type: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
REQ-007 SHALL have addr_i  in  RegBits  byte address.
REQ-008 SHALL have wdata_i  in  RegBits  store data, right-aligned.
REQ-009 SHALL have ready_o  out  1  unit idle, request accepted this cycle if req_i=1.
REQ-010 SHALL have valid_o  out  1  one-cycle completion pulse.
REQ-011 SHALL have rdata_o  out  RegBits  extended load result, held until next completion.
REQ-012 SHALL have misaligned_o  out  1  error flag, valid with valid_o.
REQ-013 SHALL have mem_a_o  out  RegBits  word-aligned data-memory address (bits [1:0]=00).
REQ-014 SHALL have mem_wd_o  out  RegBits  full write word to data memory.
REQ-015 SHALL have mem_we_o  out  1  data-memory write enable.
REQ-016 SHALL have mem_rd_i  in  RegBits  combinational data-memory read word.

Function
REQ-017 Byte lane k (bits [8k+7:8k]) of mem_rd_i/mem_wd_o SHALL correspond to byte address word_base+k.
REQ-018 FSM states SHALL be IDLE, LOAD, READ, WRITE, RESP; ready_o=1 only in IDLE.
REQ-019 On req_i in IDLE, addr, funct3, we, wdata SHALL be latched; mem_a_o SHALL equal {latched addr[31:2],00}.
REQ-020 Misaligned = halfword with addr[0]=1, word with addr[1:0]!=00, or undefined funct3 (011, 11x; for stores also 1xx); misaligned request SHALL go IDLE->RESP with misaligned_o=1, no memory write, rdata_o unchanged.
REQ-021 Aligned load SHALL go IDLE->LOAD->RESP; in LOAD the addressed lane(s) of mem_rd_i SHALL be extracted, sign-extended (LB/LH) or zero-extended (LBU/LHU), and registered into rdata_o.
REQ-022 Aligned SW SHALL go IDLE->WRITE->RESP with mem_wd_o=wdata.
REQ-023 Aligned SB/SH SHALL go IDLE->READ->WRITE->RESP; READ captures mem_rd_i; WRITE drives captured word with target lane(s) replaced by wdata[7:0] / wdata[15:0].
REQ-024 mem_we_o SHALL be 1 only in WRITE and only while rst_ni=1.
REQ-025 RESP SHALL assert valid_o for exactly one cycle, then return to IDLE.
REQ-026 Latency from accept cycle T: load valid at T+2, SW T+2, SB/SH T+3, misaligned T+1.
REQ-027 req_i outside IDLE SHALL be ignored (not queued); a request in the IDLE cycle directly after RESP SHALL be accepted (back-to-back).
REQ-028 Stores SHALL leave rdata_o unchanged; misaligned_o SHALL be 0 on every non-error completion.

Reset
REQ-029 With rst_ni=0 at a clock edge: state=IDLE, latched regs=0, rdata_o=0, misaligned_o=0, valid_o=0, mem_a_o=0, mem_wd_o=0.
REQ-030 Reset in any state SHALL abort the access; an aborted RMW SHALL produce no write and no valid_o.

Structure
REQ-031 lsu_pkg SHALL hold the FSM state enum and the funct3 encodings.
REQ-032 One combinational sub-module lsu_align SHALL implement load extract/extend and store lane merge.

Verification (memory word 0x100 = 0x884422F0)
REQ-033 LB 0x100 -> valid_o at T+2, rdata_o=0xFFFFFFF0, misaligned_o=0.
REQ-034 LHU 0x102 -> rdata_o=0x00008844; LH 0x102 -> 0xFFFF8844.
REQ-035 SB 0x101 wdata=0x000000AB -> mem_we_o only at T+2, mem_a_o=0x100, mem_wd_o=0x8844ABF0, valid_o at T+3.
REQ-036 LW 0x102 -> valid_o and misaligned_o at T+1, mem_we_o never 1, rdata_o unchanged.
REQ-037 SH 0x100 with rst_ni=0 during the WRITE cycle -> mem_we_o=0, word stays 0x884422F0, no valid_o, ready_o=1 after.
REQ-038 req_i held high across SW 0x104 then LW 0x104 -> second request accepted in the IDLE cycle after first RESP; returns stored word.
